// File: rtl/bp_cce_dir_gad_seq_pkg.sv
// Shared types for the CCE directory lookup sequencer: coherence states,
// directory entry/row layout and the sequencer FSM encoding.
package bp_cce_dir_gad_seq_pkg;

   typedef enum logic [2:0] {
      e_COH_I = 3'b000,
      e_COH_S = 3'b001,
      e_COH_E = 3'b010,
      e_COH_F = 3'b011,
      e_COH_M = 3'b110,
      e_COH_O = 3'b111
   } bp_coh_states_e;

   localparam int dir_tag_width_gp    = 12;
   localparam int dir_ways_per_row_gp = 4;

   // One directory entry: tag in the upper bits, coherence state in the low 3 bits
   typedef struct packed {
      logic [dir_tag_width_gp-1:0] tag;
      bp_coh_states_e              state;
   } bp_cce_dir_entry_s;

   // One RAM row; entry 0 occupies the least-significant bits
   typedef struct packed {
      bp_cce_dir_entry_s [dir_ways_per_row_gp-1:0] entry;
   } bp_cce_dir_row_s;

   typedef enum logic [1:0] {
      e_IDLE,
      e_READ,
      e_DRAIN,
      e_DONE
   } bp_cce_dir_seq_state_e;

   // clog2 that never returns 0, so degenerate sizes still give a legal width
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_cce_dir_row_cmp.sv
// Combinational tag compare of one directory row: per-entry match bits,
// lowest matching entry with its state, and a more-than-one-match flag.
module bp_cce_dir_row_cmp
   import bp_cce_dir_gad_seq_pkg::*;
#(
   parameter  int ways_per_row_p = 4,
   parameter  int tag_width_p    = 12,
   localparam int entry_width_lp = tag_width_p + 3,
   localparam int idx_width_lp   = safe_clog2(ways_per_row_p)
) (
   input  logic [ways_per_row_p*entry_width_lp-1:0] i_row_data,
   input  logic [tag_width_p-1:0]                   i_tag,
   output logic [ways_per_row_p-1:0]                o_match,
   output logic [idx_width_lp-1:0]                  o_idx,
   output bp_coh_states_e                           o_state,
   output logic                                     o_multi
);

   // Match every entry, then scan high-to-low so the lowest index is the last writer
   always_comb begin
      o_match = '0;
      o_idx   = '0;
      o_state = e_COH_I;
      for (int e = 0; e < ways_per_row_p; e++) begin
         o_match[e] = (i_row_data[e*entry_width_lp+3 +: tag_width_p] == i_tag)
                   && (bp_coh_states_e'(i_row_data[e*entry_width_lp +: 3]) != e_COH_I);
      end
      for (int e = ways_per_row_p - 1; e >= 0; e--) begin
         if (o_match[e]) begin
            o_idx   = idx_width_lp'(e);
            o_state = bp_coh_states_e'(i_row_data[e*entry_width_lp +: 3]);
         end
      end
   end

   // Clearing the lowest set bit leaves something only when two or more entries matched
   assign o_multi = |(o_match & (o_match - ways_per_row_p'(1)));

endmodule

// File: rtl/bp_cce_dir_gad_seq.sv
// Directory read sequencer for the CCE: streams one way-group's rows from the
// synchronous directory RAM, tag-compares each row as it returns, and holds the
// per-LCE hit/way/state vectors until the consumer takes them.
module bp_cce_dir_gad_seq
   import bp_cce_dir_gad_seq_pkg::*;
#(
   parameter  int num_lce_p          = 4,
   parameter  int lce_assoc_p        = 8,
   parameter  int ways_per_row_p     = 4,
   parameter  int num_way_groups_p   = 64,
   parameter  int tag_width_p        = 12,
   parameter  int lce_id_width_p     = 2,
   localparam int rows_per_lce_lp    = lce_assoc_p / ways_per_row_p,
   localparam int rows_per_wg_lp     = num_lce_p * rows_per_lce_lp,
   localparam int lce_assoc_width_lp = safe_clog2(lce_assoc_p),
   localparam int row_addr_width_lp  = safe_clog2(num_way_groups_p * rows_per_wg_lp),
   localparam int wg_width_lp        = safe_clog2(num_way_groups_p),
   localparam int row_width_lp       = ways_per_row_p * (tag_width_p + 3)
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic                                   req_v_i,
   output logic                                   req_ready_o,
   input  logic [wg_width_lp-1:0]                 req_wg_i,
   input  logic [tag_width_p-1:0]                 req_tag_i,
   input  logic [lce_id_width_p-1:0]              req_lce_i,
   output logic                                   dir_r_v_o,
   output logic [row_addr_width_lp-1:0]           dir_r_addr_o,
   input  logic [row_width_lp-1:0]                dir_r_data_i,
   output logic                                   sharers_v_o,
   output logic [num_lce_p-1:0]                   sharers_hits_o,
   output logic [num_lce_p*lce_assoc_width_lp-1:0] sharers_ways_o,
   output logic [num_lce_p*3-1:0]                 sharers_coh_states_o,
   output logic [lce_id_width_p-1:0]              req_lce_o,
   output logic                                   gad_v_o,
   output logic                                   multi_hit_o,
   input  logic                                   done_yumi_i
);

   localparam int cnt_width_lp = safe_clog2(rows_per_wg_lp);
   localparam int lce_width_lp = safe_clog2(num_lce_p);
   localparam int idx_width_lp = safe_clog2(ways_per_row_p);

   bp_cce_dir_seq_state_e                  r_state;
   logic                                   r_ready;
   logic                                   r_dir_v;
   logic                                   r_sharers_v;
   logic                                   r_gad_v;
   logic                                   r_multi;
   logic [cnt_width_lp-1:0]                r_cnt;
   logic                                   r_cmp_v;
   logic [cnt_width_lp-1:0]                r_cmp_row;
   logic [wg_width_lp-1:0]                 r_wg;
   logic [tag_width_p-1:0]                 r_tag;
   logic [lce_id_width_p-1:0]              r_lce;
   logic [num_lce_p-1:0]                   r_hits;
   logic [num_lce_p*lce_assoc_width_lp-1:0] r_ways;
   logic [num_lce_p*3-1:0]                 r_states;

   logic [ways_per_row_p-1:0]              w_match;
   logic [idx_width_lp-1:0]                w_idx;
   bp_coh_states_e                         w_cmp_state;
   logic                                   w_multi;
   logic                                   w_any;
   logic [lce_width_lp-1:0]                w_lce;
   logic [lce_assoc_width_lp-1:0]          w_way;
   logic [row_addr_width_lp-1:0]           w_addr;

   bp_cce_dir_row_cmp #(
      .ways_per_row_p (ways_per_row_p),
      .tag_width_p    (tag_width_p)
   ) u_row_cmp (
      .i_row_data (dir_r_data_i),
      .i_tag      (r_tag),
      .o_match    (w_match),
      .o_idx      (w_idx),
      .o_state    (w_cmp_state),
      .o_multi    (w_multi)
   );

   assign w_any  = |w_match;
   // Row r belongs to LCE r/rows_per_lce; its entries cover ways starting at (r%rows_per_lce)*ways_per_row
   assign w_lce  = lce_width_lp'(int'(r_cmp_row) / rows_per_lce_lp);
   assign w_way  = lce_assoc_width_lp'((int'(r_cmp_row) % rows_per_lce_lp) * ways_per_row_p + int'(w_idx));
   assign w_addr = row_addr_width_lp'(r_wg) * row_addr_width_lp'(rows_per_wg_lp)
                 + row_addr_width_lp'(r_cnt);

   // Sequencer FSM with accumulation of the row returned by the previous read
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state     <= e_IDLE;
         r_ready     <= 1'b0;
         r_dir_v     <= 1'b0;
         r_sharers_v <= 1'b0;
         r_gad_v     <= 1'b0;
         r_multi     <= 1'b0;
         r_cnt       <= '0;
         r_cmp_v     <= 1'b0;
         r_cmp_row   <= '0;
         r_wg        <= '0;
         r_tag       <= '0;
         r_lce       <= '0;
         r_hits      <= '0;
         r_ways      <= '0;
         r_states    <= '0;
      end else begin
         r_gad_v   <= 1'b0;
         r_cmp_v   <= (r_state == e_READ);
         r_cmp_row <= r_cnt;

         // Rows arrive in increasing way order, so a repeat hit never displaces the stored way
         if (r_cmp_v && w_any) begin
            if (!r_hits[w_lce]) begin
               r_hits[w_lce]                                      <= 1'b1;
               r_ways[w_lce*lce_assoc_width_lp +: lce_assoc_width_lp] <= w_way;
               r_states[w_lce*3 +: 3]                             <= w_cmp_state;
               if (w_multi) r_multi <= 1'b1;
            end else begin
               r_multi <= 1'b1;
            end
         end

         case (r_state)
            e_IDLE: begin
               r_ready <= 1'b1;
               if (req_v_i && r_ready) begin
                  r_wg     <= req_wg_i;
                  r_tag    <= req_tag_i;
                  r_lce    <= req_lce_i;
                  r_hits   <= '0;
                  r_ways   <= '0;
                  r_states <= '0;
                  r_multi  <= 1'b0;
                  r_cnt    <= '0;
                  r_ready  <= 1'b0;
                  r_dir_v  <= 1'b1;
                  r_state  <= e_READ;
               end
            end
            e_READ: begin
               if (r_cnt == cnt_width_lp'(rows_per_wg_lp - 1)) begin
                  r_cnt   <= '0;
                  r_dir_v <= 1'b0;
                  r_state <= e_DRAIN;
               end else begin
                  r_cnt <= r_cnt + cnt_width_lp'(1);
               end
            end
            e_DRAIN: begin
               r_sharers_v <= 1'b1;
               r_gad_v     <= 1'b1;
               r_state     <= e_DONE;
            end
            e_DONE: begin
               if (done_yumi_i) begin
                  r_sharers_v <= 1'b0;
                  r_ready     <= 1'b1;
                  r_state     <= e_IDLE;
               end
            end
            default: r_state <= e_IDLE;
         endcase
      end
   end

   assign req_ready_o          = r_ready;
   assign dir_r_v_o            = r_dir_v;
   assign dir_r_addr_o         = w_addr;
   assign sharers_v_o          = r_sharers_v;
   assign sharers_hits_o       = r_hits;
   assign sharers_ways_o       = r_ways;
   assign sharers_coh_states_o = r_states;
   assign req_lce_o            = r_lce;
   assign gad_v_o              = r_gad_v;
   assign multi_hit_o          = r_multi;

endmodule
